softreg_cfg_responder: RTL
==========================

Name: softreg_cfg_responder

Overview:
- Responder side of the SoftReg interface, inside the accelerator.
- Decodes host SoftReg writes into the PageRank configuration registers: vertex count, in-edge count, vertex and in-edge base addresses, and the two ping-pong write buffers.
- Issues a one-cycle start pulse to the PageRank engine.
- Answers SoftReg reads; a read of DONE_ALL is held until the engine reports completion, then returns the engine's result.

Parameters:
- A_N_VERT, 32'h00, SoftReg address of vertex count
- A_N_INEDGES, 32'h08, address of in-edge count
- A_VADDR, 32'h10, address of vertex array base (byte address)
- A_IEADDR, 32'h18, address of in-edge array base (byte address)
- A_WADDR0, 32'h20, address of write buffer 0 base
- A_WADDR1, 32'h28, address of write buffer 1 base
- A_START, 32'h30, address of DONE_READ_PARAMS (start command)
- A_DONE_ALL, 32'h38, address of blocking completion read
- A_STATUS, 32'h40, address of status register

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  asynchronous active-low reset
- softreg_req_valid  in  1  request strobe, one cycle per request
- softreg_req_isWrite  in  1  1 = write, 0 = read
- softreg_req_addr  in  32  register address
- softreg_req_data  in  64  write data
- softreg_resp_valid  out  1  read response strobe, one cycle
- softreg_resp_data  out  64  read response data
- n_vert, n_inedges, vaddr, ieaddr, write_addr0, write_addr1  out  64 each  configuration values to the engine
- start  out  1  one-cycle pulse that launches the engine
- busy  out  1  high from start until completion is acknowledged
- accel_done  in  1  one-cycle completion pulse from the engine
- accel_result  in  64  result value, valid while accel_done is high

Behaviour:
- Reset (rst low, asynchronous):
  - All config outputs = 0; start = 0; busy = 0; softreg_resp_valid = 0; softreg_resp_data = 0.
  - State = IDLE; done_latched = 0; result_q = 0; err = 0.
  - Reset mid-run discards any pending DONE_ALL read; no response is ever issued for it.
- States:
  - IDLE: accepting configuration.
  - RUN: engine running.
  - DONE: result latched.
- Writes (valid & isWrite):
  - In IDLE, a matching config address loads the register on the next posedge.
  - In RUN or DONE, config writes are ignored and set err.
  - Writes to unmapped addresses are ignored; err is unchanged.
- Write to A_START:
  - In IDLE: start = 1 for exactly the next cycle, busy = 1, state goes to RUN. The data value is ignored.
  - In RUN: ignored, sets err.
  - In DONE: clears done_latched, then behaves as in IDLE (relaunch with the current config).
- accel_done:
  - In RUN: latch accel_result into result_q, set done_latched, state goes to DONE.
  - Outside RUN: ignored.
- Reads (valid & !isWrite), non-blocking:
  - Config, A_START (returns 0), unmapped (returns 0), and A_STATUS addresses respond with fixed latency 1: resp_valid is high on the cycle after the request.
  - A_STATUS data = {61'b0, err, done_latched, busy}.
- Reads of A_DONE_ALL, blocking:
  - Sets pend.
  - If done_latched is already 1: respond with result_q after 1 cycle.
  - Otherwise: respond 1 cycle after the accel_done pulse, with accel_result.
  - On response: busy = 0 and state goes to IDLE. done_latched stays 1 until the next start.
- At most one DONE_ALL read is outstanding. Another read arriving while pend is set is dropped (no response) and sets err.
- Simultaneous events:
  - accel_done in the same cycle as a DONE_ALL request: respond next cycle with accel_result.
  - A non-blocking read response and the DONE_ALL response are never due in the same cycle, because reads are rejected while pend is set.
- err is sticky. It is cleared only by reset, or by a write of any value to A_STATUS.
- softreg_resp_valid is never high for two consecutive cycles from a single request.

Test Plan:
- Write n_vert = 10, n_inedges = 47, vaddr = 0, ieaddr = 160, waddr0 = 1240, waddr1 = 1360, then A_START → outputs hold those values; start high for exactly 1 cycle, 1 cycle after the START request; busy = 1.
- Read A_DONE_ALL at cycle T; pulse accel_done at T+20 with result 0x1234 → resp_valid only at T+21, data 0x1234; busy drops; STATUS reads 0b010.
- accel_done with 0xBEEF at T; read DONE_ALL at T+5 → response at T+6 with 0xBEEF.
- Write n_vert = 99 while RUN → n_vert stays 10; STATUS err bit = 1; write to A_STATUS → err = 0.
- Read n_inedges in IDLE → response next cycle with 47. A second read issued while DONE_ALL is pending → no response; err = 1.
- Assert rst low while DONE_ALL is pending, release, then pulse accel_done → no response; all outputs 0; state IDLE.

Source files
------------

// File: rtl/softreg_cfg_responder.sv
// softreg_cfg_responder: responder side of the SoftReg interface inside the
// accelerator. Holds the PageRank configuration registers, launches the
// engine with a one-cycle start pulse, and answers host reads. A read of
// DONE_ALL blocks until the engine reports completion.
module softreg_cfg_responder #(
    parameter logic [31:0] A_N_VERT    = 32'h00,
    parameter logic [31:0] A_N_INEDGES = 32'h08,
    parameter logic [31:0] A_VADDR     = 32'h10,
    parameter logic [31:0] A_IEADDR    = 32'h18,
    parameter logic [31:0] A_WADDR0    = 32'h20,
    parameter logic [31:0] A_WADDR1    = 32'h28,
    parameter logic [31:0] A_START     = 32'h30,
    parameter logic [31:0] A_DONE_ALL  = 32'h38,
    parameter logic [31:0] A_STATUS    = 32'h40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        softreg_req_valid,
    input  logic        softreg_req_isWrite,
    input  logic [31:0] softreg_req_addr,
    input  logic [63:0] softreg_req_data,
    output logic        softreg_resp_valid,
    output logic [63:0] softreg_resp_data,
    output logic [63:0] n_vert,
    output logic [63:0] n_inedges,
    output logic [63:0] vaddr,
    output logic [63:0] ieaddr,
    output logic [63:0] write_addr0,
    output logic [63:0] write_addr1,
    output logic        start,
    output logic        busy,
    input  logic        accel_done,
    input  logic [63:0] accel_result
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      state;
    logic        done_latched;
    logic        pend;
    logic        err;
    logic [63:0] result_q;

    logic        req_wr;
    logic        req_rd;
    logic        done_evt;
    logic        cfg_hit;
    logic [63:0] rd_data;

    assign req_wr   = softreg_req_valid & softreg_req_isWrite;
    assign req_rd   = softreg_req_valid & ~softreg_req_isWrite;
    // Completion only counts while the engine is actually running.
    assign done_evt = accel_done & (state == S_RUN);

    // Decode the request address into a config-register hit and the non-blocking read value.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        cfg_hit = 1'b1;
        rd_data = '0;
        case (softreg_req_addr)
            A_N_VERT:    rd_data = n_vert;
            A_N_INEDGES: rd_data = n_inedges;
            A_VADDR:     rd_data = vaddr;
            A_IEADDR:    rd_data = ieaddr;
            A_WADDR0:    rd_data = write_addr0;
            A_WADDR1:    rd_data = write_addr1;
            A_STATUS: begin
                cfg_hit = 1'b0;
                rd_data = {61'b0, err, done_latched, busy};
            end
            default:     cfg_hit = 1'b0;
        endcase
    end

    // Configuration registers, run sequencing, error tracking and read responses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: config registers are reset too, so the engine never sees stale values after reset.
            n_vert             <= '0;
            n_inedges          <= '0;
            vaddr              <= '0;
            ieaddr             <= '0;
            write_addr0        <= '0;
            write_addr1        <= '0;
            start              <= 1'b0;
            busy               <= 1'b0;
            softreg_resp_valid <= 1'b0;
            softreg_resp_data  <= '0;
            state              <= S_IDLE;
            done_latched       <= 1'b0;
            pend               <= 1'b0;
            err                <= 1'b0;
            result_q           <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch below sees pre-edge state
            // and a later branch in this block deliberately overrides an earlier one.
            start              <= 1'b0;
            softreg_resp_valid <= 1'b0;

            if (done_evt) begin
                result_q     <= accel_result;
                done_latched <= 1'b1;
                state        <= S_DONE;
                if (pend) begin
                    // The blocked DONE_ALL read is answered one cycle after the pulse.
                    pend               <= 1'b0;
                    softreg_resp_valid <= 1'b1;
                    softreg_resp_data  <= accel_result;
                    busy               <= 1'b0;
                    state              <= S_IDLE;
                end
            end

            if (req_wr) begin
                if (cfg_hit) begin
                    if (state == S_IDLE) begin
                        case (softreg_req_addr)
                            A_N_VERT:    n_vert      <= softreg_req_data;
                            A_N_INEDGES: n_inedges   <= softreg_req_data;
                            A_VADDR:     vaddr       <= softreg_req_data;
                            A_IEADDR:    ieaddr      <= softreg_req_data;
                            A_WADDR0:    write_addr0 <= softreg_req_data;
                            A_WADDR1:    write_addr1 <= softreg_req_data;
                            default:     ;
                        endcase
                    end else begin
                        err <= 1'b1;
                    end
                end else if (softreg_req_addr == A_START) begin
                    if (state == S_RUN) begin
                        err <= 1'b1;
                    end else begin
                        // Launch (or relaunch from DONE) with the current configuration.
                        start        <= 1'b1;
                        busy         <= 1'b1;
                        done_latched <= 1'b0;
                        state        <= S_RUN;
                    end
                end else if (softreg_req_addr == A_STATUS) begin
                    err <= 1'b0;
                end
            end

            if (req_rd) begin
                if (pend) begin
                    // Only one DONE_ALL read may be outstanding; anything else is dropped.
                    err <= 1'b1;
                end else if (softreg_req_addr == A_DONE_ALL) begin
                    if (done_latched || done_evt) begin
                        softreg_resp_valid <= 1'b1;
                        softreg_resp_data  <= done_latched ? result_q : accel_result;
                        busy               <= 1'b0;
                        state              <= S_IDLE;
                    end else begin
                        pend <= 1'b1;
                    end
                end else begin
                    softreg_resp_valid <= 1'b1;
                    softreg_resp_data  <= rd_data;
                end
            end
        end
    end

endmodule
